// File: rtl/offnariscv_pkg.sv
// Shared types for the PC generator: PC stream payload, PC step and FSM states.
package offnariscv_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
  } pcgif_tdata_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } pc_gen_state_e;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream handshake interface (tvalid/tready/tdata).
interface axis_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pc_gen.sv
// Program counter generator feeding the fetch unit over AXI-Stream.
// Optional target alignment check/force enabled by PC_GEN_ALIGN_CHECK_EN.
//
// state  | meaning
// BOOT   | first cycle after reset, no offer
// RUN    | offering pc_q, +4 on each ack
// FLUSH  | invalidate pulse, redirect target loaded into pc_q
// HALTED | halt requested, no offer, pc_q frozen
module pc_gen
  import offnariscv_pkg::*;
#(
  parameter int                XLEN_P       = XLEN,
  parameter logic [XLEN_P-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  axis_if.m                 pcgif_axis_if,
  input  logic              trap_redirect_valid,
  input  logic [XLEN_P-1:0] trap_redirect_pc,
  input  logic              br_redirect_valid,
  input  logic [XLEN_P-1:0] br_redirect_pc,
  input  logic              halt,
  output logic              invalidate
`ifdef PC_GEN_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  pc_gen_state_e     state_q, state_d;
  logic [XLEN_P-1:0] pc_q, pc_d;
  logic              invalidate_q, invalidate_d;
  logic              redir;
  logic [XLEN_P-1:0] raw_target;
  logic [XLEN_P-1:0] target;
  logic              offer;
  logic              ack;

`ifdef PC_GEN_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      invalidate_q <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      invalidate_q <= invalidate_d;
`ifdef PC_GEN_ALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Trap wins over branch; the losing request is dropped, not queued.
  always_comb begin
    redir      = trap_redirect_valid | br_redirect_valid;
    raw_target = trap_redirect_valid ? trap_redirect_pc : br_redirect_pc;
`ifdef PC_GEN_ALIGN_CHECK_EN
    target     = {raw_target[XLEN_P-1:2], 2'b00};
`else
    target     = raw_target;
`endif
  end

  always_comb begin
    offer        = (state_q == RUN);
    ack          = offer & pcgif_axis_if.tready;
    state_d      = state_q;
    pc_d         = pc_q;
    invalidate_d = 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif
    if (redir) begin
      // A same-cycle ack of the old PC is discarded along with it.
      state_d      = FLUSH;
      pc_d         = target;
      invalidate_d = 1'b1;
`ifdef PC_GEN_ALIGN_CHECK_EN
      misalign_d   = |raw_target[1:0];
`endif
    end else begin
      unique case (state_q)
        BOOT:  state_d = RUN;
        RUN: begin
          if (ack) begin
            pc_d = pc_q + XLEN_P'(PC_STEP);
            if (halt) state_d = HALTED;
          end
        end
        FLUSH:  state_d = halt ? HALTED : RUN;
        HALTED: if (!halt) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    pcgif_axis_if.tvalid = (state_q == RUN);
    pcgif_axis_if.tdata  = pcgif_tdata_t'{pc: XLEN'(pc_q)};
    invalidate           = invalidate_q;
`ifdef PC_GEN_ALIGN_CHECK_EN
    misalign             = misalign_q;
`endif
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-cycle vector table through a scoreboard queue.
module tb_pc_gen;
  import offnariscv_pkg::*;

  localparam logic [31:0] RV = 32'h8000_0000;
`ifdef PC_GEN_ALIGN_CHECK_EN
  localparam logic        MIS_EXP = 1'b1;
  localparam logic [31:0] PC42    = 32'h8000_0040;
`else
  localparam logic        MIS_EXP = 1'b0;
  localparam logic [31:0] PC42    = 32'h8000_0042;
`endif

  typedef struct {
    logic        tready;
    logic        halt;
    logic        tv;
    logic [31:0] tpc;
    logic        bv;
    logic [31:0] bpc;
    logic        e_tvalid;
    logic [31:0] e_pc;
    logic        e_inv;
    logic        e_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_redirect_valid, br_redirect_valid, halt;
  logic [31:0] trap_redirect_pc, br_redirect_pc;
  logic        invalidate;
  logic        misalign_w;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          bad_emit = 0;
  vec_t        vecs[$];
  vec_t        exp_q[$];

  axis_if #(.W($bits(pcgif_tdata_t))) pcg_if ();

  pc_gen #(.XLEN_P(32), .RESET_VECTOR(RV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pcgif_axis_if       (pcg_if),
    .trap_redirect_valid (trap_redirect_valid),
    .trap_redirect_pc    (trap_redirect_pc),
    .br_redirect_valid   (br_redirect_valid),
    .br_redirect_pc      (br_redirect_pc),
    .halt                (halt),
    .invalidate          (invalidate)
`ifdef PC_GEN_ALIGN_CHECK_EN
    ,
    .misalign            (misalign_w)
`endif
  );

`ifndef PC_GEN_ALIGN_CHECK_EN
  assign misalign_w = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && pcg_if.tvalid && pcg_if.tready && pcg_if.tdata[31:0] == 32'h8000_0014)
      bad_emit++;

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
  endtask

  function automatic void add(input logic tr, input logic h,
                              input logic tv, input logic [31:0] tpc,
                              input logic bv, input logic [31:0] bpc,
                              input logic etv, input logic [31:0] epc,
                              input logic einv, input logic emis);
    vec_t v;
    v.tready = tr; v.halt = h; v.tv = tv; v.tpc = tpc; v.bv = bv; v.bpc = bpc;
    v.e_tvalid = etv; v.e_pc = epc; v.e_inv = einv; v.e_mis = emis;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(input int row, input vec_t e);
    chk("tvalid", row, {31'd0, pcg_if.tvalid}, {31'd0, e.e_tvalid});
    chk("invalidate", row, {31'd0, invalidate}, {31'd0, e.e_inv});
    chk("misalign", row, {31'd0, misalign_w}, {31'd0, e.e_mis});
    if (e.e_tvalid) chk("pc", row, pcg_if.tdata[31:0], e.e_pc);
  endtask

  initial begin
    vec_t e, cur;
    rst = 1'b1; halt = 1'b0; pcg_if.tready = 1'b1;
    trap_redirect_valid = 1'b0; br_redirect_valid = 1'b0;
    trap_redirect_pc = '0; br_redirect_pc = '0;

    //  tr h  trap              br                 exp tv pc              inv mis
    add(1, 0, 0, 0,             0, 0,              0, 0,             0, 0);       // 0 BOOT
    add(1, 0, 0, 0,             0, 0,              1, 32'h8000_0000, 0, 0);
    add(0, 0, 0, 0,             0, 0,              1, 32'h8000_0004, 0, 0);
    add(0, 0, 0, 0,             0, 0,              1, 32'h8000_0004, 0, 0);
    add(0, 0, 0, 0,             0, 0,              1, 32'h8000_0004, 0, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h8000_0004, 0, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h8000_0008, 0, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h8000_000C, 0, 0);
    add(1, 0, 1, 32'h0000_0100, 1, 32'h8000_0040, 1, 32'h8000_0010, 0, 0);       // 8 trap+br+ack
    add(1, 0, 0, 0,             0, 0,              0, 0,             1, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h0000_0100, 0, 0);
    add(1, 0, 0, 0,             1, 32'h8000_0040, 1, 32'h0000_0104, 0, 0);
    add(1, 0, 0, 0,             1, 32'h8000_0080, 0, 0,             1, 0);       // 12 redirect in FLUSH
    add(1, 0, 0, 0,             0, 0,              0, 0,             1, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h8000_0080, 0, 0);
    add(1, 0, 0, 0,             1, 32'hFFFF_FFFC, 1, 32'h8000_0084, 0, 0);
    add(1, 0, 0, 0,             0, 0,              0, 0,             1, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'hFFFF_FFFC, 0, 0);       // 17 wrap
    add(0, 1, 0, 0,             0, 0,              1, 32'h0000_0000, 0, 0);
    add(0, 1, 0, 0,             0, 0,              1, 32'h0000_0000, 0, 0);
    add(1, 1, 0, 0,             0, 0,              1, 32'h0000_0000, 0, 0);       // 20 ack under halt
    add(1, 1, 0, 0,             0, 0,              0, 0,             0, 0);
    add(1, 0, 0, 0,             0, 0,              0, 0,             0, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h0000_0004, 0, 0);
    add(1, 1, 0, 0,             0, 0,              1, 32'h0000_0008, 0, 0);
    add(1, 1, 1, 32'h0000_0200, 0, 0,              0, 0,             0, 0);       // 25 trap in HALTED
    add(1, 1, 0, 0,             0, 0,              0, 0,             1, 0);
    add(1, 0, 0, 0,             0, 0,              0, 0,             0, 0);
    add(1, 0, 0, 0,             0, 0,              1, 32'h0000_0200, 0, 0);
    add(1, 0, 0, 0,             1, 32'h8000_0042, 1, 32'h0000_0204, 0, 0);       // 29 misaligned target
    add(1, 0, 0, 0,             0, 0,              0, 0,             1, MIS_EXP);
    add(0, 0, 0, 0,             0, 0,              1, PC42,          0, 0);
    add(0, 0, 0, 0,             0, 0,              1, PC42,          0, 0);

    repeat (3) @(negedge clk);
    #1;
    e = '{default: '0};
    check_outputs(-1, e);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      cur = vecs[i];
      pcg_if.tready       = cur.tready;
      halt                = cur.halt;
      trap_redirect_valid = cur.tv;
      trap_redirect_pc    = cur.tpc;
      br_redirect_valid   = cur.bv;
      br_redirect_pc      = cur.bpc;
      exp_q.push_back(cur);
      #1;
      e = exp_q.pop_front();
      check_outputs(i, e);
    end

    // Reset with a redirect pending at the same edge: redirect must be lost.
    @(negedge clk);
    rst = 1'b1; pcg_if.tready = 1'b1;
    br_redirect_valid = 1'b1; br_redirect_pc = 32'h8000_0100;
    @(negedge clk);
    rst = 1'b0; br_redirect_valid = 1'b0;
    #1;
    e = '{default: '0};
    check_outputs(100, e);
    @(negedge clk);
    #1;
    e.e_tvalid = 1'b1; e.e_pc = RV;
    check_outputs(101, e);

    chk("no_8000_0014", 102, bad_emit, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
